// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with forwarding, operand select and load-use detect
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_dst_addr,
  input  logic          id_alusrc_a,
  input  logic          id_alusrc_b,
  input  logic [5:0]    id_alufun,
  input  logic          id_sign,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [5:0]    alu_fun,
  output logic          alu_sign,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dst_addr,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_valid,
  output logic          load_use_hazard
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    shamt;
    logic [RW-1:0] rs_addr;
    logic [RW-1:0] rt_addr;
    logic [RW-1:0] dst_addr;
    logic          alusrc_a;
    logic          alusrc_b;
    logic [5:0]    alufun;
    logic          sign;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
  } ex_t;

  ex_t ex_q, ex_d, id_pkt;
  logic [DW-1:0] fwd_rs, fwd_rt;

  always_comb begin
    id_pkt.valid    = 1'b1;
    id_pkt.rs_data  = id_rs_data;
    id_pkt.rt_data  = id_rt_data;
    id_pkt.imm      = id_imm;
    id_pkt.shamt    = id_shamt;
    id_pkt.rs_addr  = id_rs_addr;
    id_pkt.rt_addr  = id_rt_addr;
    id_pkt.dst_addr = id_dst_addr;
    id_pkt.alusrc_a = id_alusrc_a;
    id_pkt.alusrc_b = id_alusrc_b;
    id_pkt.alufun   = id_alufun;
    id_pkt.sign     = id_sign;
    id_pkt.regwrite = id_regwrite;
    id_pkt.memread  = id_memread;
    id_pkt.memwrite = id_memwrite;
    id_pkt.memtoreg = id_memtoreg;
  end

  // The bubble clears ex_memread, so the hazard self-releases after one cycle.
  assign load_use_hazard = ex_q.valid && ex_q.memread && (ex_q.dst_addr != '0) &&
                           ((ex_q.dst_addr == id_rs_addr) || (ex_q.dst_addr == id_rt_addr));

  always_comb begin
    ex_d = id_pkt;
    if (flush)
      ex_d = '0;
    else if (stall)
      ex_d = ex_q;
    else if (load_use_hazard)
      ex_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  // Nearest producer wins; register 0 is hardwired and never forwarded.
  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] idx, input logic [DW-1:0] reg_val);
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idx))
      return exmem_result;
    else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idx))
      return memwb_result;
    else
      return reg_val;
  endfunction

  assign fwd_rs = fwd(ex_q.rs_addr, ex_q.rs_data);
  assign fwd_rt = fwd(ex_q.rt_addr, ex_q.rt_data);

  assign alu_a         = ex_q.alusrc_a ? {{(DW-5){1'b0}}, ex_q.shamt} : fwd_rs;
  assign alu_b         = ex_q.alusrc_b ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_fun       = ex_q.alufun;
  assign alu_sign      = ex_q.sign;
  assign ex_dst_addr   = ex_q.dst_addr;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_memtoreg   = ex_q.memtoreg;
  assign ex_valid      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset, stall, flush;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]    id_shamt;
  logic [RW-1:0] id_rs_addr, id_rt_addr, id_dst_addr;
  logic          id_alusrc_a, id_alusrc_b;
  logic [5:0]    id_alufun;
  logic          id_sign, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic          exmem_regwrite, memwb_regwrite;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [DW-1:0] alu_a, alu_b, ex_store_data;
  logic [5:0]    alu_fun;
  logic          alu_sign;
  logic [RW-1:0] ex_dst_addr;
  logic          ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_valid, load_use_hazard;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_dst_addr(id_dst_addr),
    .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b), .id_alufun(id_alufun), .id_sign(id_sign),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .ex_store_data(ex_store_data), .ex_dst_addr(ex_dst_addr),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_valid(ex_valid), .load_use_hazard(load_use_hazard)
  );

  // Reference model: what instruction sits in EX, as plain variables.
  logic          m_valid, m_asa, m_asb, m_sign, m_rw, m_mr, m_mw, m_mtr;
  logic [DW-1:0] m_rs, m_rt, m_imm;
  logic [4:0]    m_sh;
  logic [RW-1:0] m_rsa, m_rta, m_dst;
  logic [5:0]    m_fun;

  function automatic logic m_hazard();
    return m_valid && m_mr && m_dst != 0 && (m_dst == id_rs_addr || m_dst == id_rt_addr);
  endfunction

  function automatic logic [DW-1:0] m_operand(input logic [RW-1:0] idx, input logic [DW-1:0] v);
    if (idx == 0) return v;
    if (exmem_regwrite && exmem_rd == idx) return exmem_result;
    if (memwb_regwrite && memwb_rd == idx) return memwb_result;
    return v;
  endfunction

  task automatic m_clear();
    {m_valid, m_asa, m_asb, m_sign, m_rw, m_mr, m_mw, m_mtr} = '0;
    {m_rs, m_rt, m_imm, m_sh, m_rsa, m_rta, m_dst, m_fun} = '0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset || flush || (!stall && m_hazard())) m_clear();
    else if (!stall) begin
      m_valid = 1; m_rs = id_rs_data; m_rt = id_rt_data; m_imm = id_imm; m_sh = id_shamt;
      m_rsa = id_rs_addr; m_rta = id_rt_addr; m_dst = id_dst_addr; m_asa = id_alusrc_a;
      m_asb = id_alusrc_b; m_fun = id_alufun; m_sign = id_sign; m_rw = id_regwrite;
      m_mr = id_memread; m_mw = id_memwrite; m_mtr = id_memtoreg;
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] ea, eb, es;
    es = m_operand(m_rta, m_rt);
    ea = m_asa ? DW'(m_sh) : m_operand(m_rsa, m_rs);
    eb = m_asb ? m_imm : es;
    checks++;
    if (alu_a !== ea || alu_b !== eb || ex_store_data !== es) begin
      errors++;
      $display("FAIL model_operands t=%0t a=%h b=%h st=%h required a=%h b=%h st=%h",
               $time, alu_a, alu_b, ex_store_data, ea, eb, es);
    end
    checks++;
    if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, alu_sign, alu_fun, ex_dst_addr, load_use_hazard}
        !== {m_valid, m_rw, m_mr, m_mw, m_mtr, m_sign, m_fun, m_dst, m_hazard()}) begin
      errors++;
      $display("FAIL model_ctrl t=%0t v=%b rw=%b mr=%b mw=%b mtr=%b sg=%b fun=%h dst=%0d hz=%b required v=%b rw=%b mr=%b mw=%b mtr=%b sg=%b fun=%h dst=%0d hz=%b",
               $time, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, alu_sign, alu_fun, ex_dst_addr, load_use_hazard,
               m_valid, m_rw, m_mr, m_mw, m_mtr, m_sign, m_fun, m_dst, m_hazard());
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_nop();
    {id_rs_data, id_rt_data, id_imm, id_shamt, id_rs_addr, id_rt_addr, id_dst_addr} = '0;
    {id_alusrc_a, id_alusrc_b, id_alufun, id_sign, id_regwrite, id_memread, id_memwrite, id_memtoreg} = '0;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    id_nop();
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    #1;
    check("reset_valid", DW'(ex_valid), 0);
    check("reset_alu_a", alu_a, 0);
    step(); step();
    reset = 0;

    // Plain load, no forwarding.
    id_rs_data = 5; id_rt_data = 7; id_rs_addr = 1; id_rt_addr = 2; id_dst_addr = 3; id_regwrite = 1;
    step();
    check("load_alu_a", alu_a, 5);
    check("load_alu_b", alu_b, 7);
    check("load_valid", DW'(ex_valid), 1);

    // $3 produced in both later stages.
    id_rs_addr = 3; id_rs_data = 32'h99;
    exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'h11;
    memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'h22;
    step();
    check("fwd_both", alu_a, 32'h11);
    exmem_regwrite = 0; #1;
    check("fwd_memwb", alu_a, 32'h22);
    exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0; #1;
    check("fwd_r0", alu_a, 32'h99);
    exmem_regwrite = 0; memwb_regwrite = 0;
    step();

    // lw $4 then consumer of $4.
    id_nop(); id_memread = 1; id_regwrite = 1; id_memtoreg = 1; id_dst_addr = 4; id_rs_addr = 1; id_rt_addr = 2;
    step();
    id_nop(); id_rs_addr = 4; id_rt_addr = 2; id_dst_addr = 5; id_regwrite = 1; id_rs_data = 32'h44; #1;
    check("lu_hazard", DW'(load_use_hazard), 1);
    step();
    check("lu_bubble_valid", DW'(ex_valid), 0);
    check("lu_bubble_memread", DW'(ex_memread), 0);
    check("lu_hazard_clear", DW'(load_use_hazard), 0);
    step();
    check("lu_reissue_valid", DW'(ex_valid), 1);
    check("lu_reissue_a", alu_a, 32'h44);

    // Stall holds three cycles, then flush beats stall.
    id_nop(); id_rs_addr = 8; id_rs_data = 32'h55; id_regwrite = 1; id_dst_addr = 9;
    step();
    stall = 1; id_rs_data = 32'h66; id_alufun = 6'h21;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_a", alu_a, 32'h55);
      check("stall_hold_valid", DW'(ex_valid), 1);
    end
    flush = 1;
    step();
    check("flush_over_stall", DW'(ex_valid), 0);
    check("flush_regwrite", DW'(ex_regwrite), 0);
    stall = 0; flush = 0;

    // sll $x, $6, 4
    id_nop(); id_alusrc_a = 1; id_shamt = 4; id_rt_addr = 6; id_rt_data = 1; id_rs_data = 32'hDEAD; id_alufun = 6'h20;
    step();
    check("sll_a", alu_a, 4);
    check("sll_b", alu_b, 1);

    // sw with rt forwarded from EX/MEM.
    id_nop(); id_alusrc_b = 1; id_imm = 8; id_rt_addr = 7; id_rs_addr = 10; id_memwrite = 1;
    exmem_regwrite = 1; exmem_rd = 7; exmem_result = 32'hAB;
    step();
    check("sw_b", alu_b, 8);
    check("sw_store", ex_store_data, 32'hAB);
    exmem_regwrite = 0;

    // Reset between edges acts without a clock.
    id_nop(); id_rs_data = 32'h77; id_rs_addr = 11; id_memread = 1; id_dst_addr = 12; id_regwrite = 1;
    step();
    id_rs_addr = 12; #2;
    check("pre_reset_hazard", DW'(load_use_hazard), 1);
    reset = 1; #1;
    check("async_valid", DW'(ex_valid), 0);
    check("async_alu_a", alu_a, 0);
    check("async_alu_b", alu_b, 0);
    check("async_memread", DW'(ex_memread), 0);
    check("async_hazard", DW'(load_use_hazard), 0);
    step();
    reset = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
